// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Sequences one doubleword load (ld) or store (sd) at a time between the
//   datapath and the shared data-memory bus. The unit turns the byte address
//   into a word index and rejects misaligned or out-of-range requests. It owns
//   the turnaround of the tristate data bus, and it signals each completion
//   with a one-cycle response pulse.
//
// Ports
//   clk         in     system clock, rising edge
//   reset       in     asynchronous, active-high
//   req_valid   in     request present
//   req_write   in     1 = store, 0 = load
//   req_addr    in     [63:0] byte address
//   req_wdata   in     [63:0] store data
//   req_ready   out    unit idle; request accepted on valid && ready
//   rsp_valid   out    one-cycle completion pulse
//   rsp_rdata   out    [63:0] last loaded doubleword
//   rsp_err     out    qualifies rsp_valid: misaligned or out of range
//   d_mem_we    out    data-memory write enable (registered)
//   d_mem_addr  out    [D_ADDR_BITS-1:0] data-memory word index
//   d_mem_data  inout  [63:0] shared bus, driven here only while d_mem_we = 1
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int D_ADDR_BITS = 6,
  parameter int MEM_WORDS   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [63:0]            req_addr,
  input  logic [63:0]            req_wdata,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [63:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   d_mem_we,
  output logic [D_ADDR_BITS-1:0] d_mem_addr,
  inout  wire  [63:0]            d_mem_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam logic [60:0] LIMIT = 61'(MEM_WORDS);

  state_e                 state_q, state_d;
  logic [D_ADDR_BITS-1:0] addr_q,  addr_d;
  logic [63:0]            wdata_q, wdata_d;
  logic [63:0]            rdata_q, rdata_d;
  logic                   we_q,    we_d;

  logic accept;
  logic bad_req;

  assign accept  = req_valid && (state_q == IDLE);
  // The upper address bits take part in the range check. A large address
  // therefore cannot alias into the populated words through the truncated
  // index.
  assign bad_req = (|req_addr[2:0]) || (req_addr[63:3] >= LIMIT);

  // State register plus datapath registers.
  // NOTE: sequential state uses non-blocking assignments only. This keeps
  // every flop sampling the pre-edge values regardless of process order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
    end
  end

  // Next-state and next-datapath logic.
  // NOTE: every signal gets a default before the case statement, so no path
  // through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // The address changes only here, never while we is high, because
          // the memory write is level-sensitive.
          addr_d  = req_addr[D_ADDR_BITS+2:3];
          wdata_d = req_wdata;
          if (bad_req)        state_d = ERR;
          else if (req_write) state_d = WR;
          else                state_d = RD;
        end
      end
      RD: begin
        // The memory has driven the bus for this whole cycle at a stable
        // address.
        rdata_d = d_mem_data;
        state_d = RESP;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Register we from the next state. It is then high for exactly the WR
    // cycle, and reset clears it asynchronously.
    we_d = (state_d == WR);
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP) || (state_q == ERR);
    rsp_err   = (state_q == ERR);
  end

  assign rsp_rdata  = rdata_q;
  assign d_mem_we   = we_q;
  assign d_mem_addr = addr_q;

  // The tristate enable is the registered we itself. The memory drives the
  // bus only while we is low, so the two drivers never overlap.
  assign d_mem_data = we_q ? wdata_q : 64'bz;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit. It contains a small 32-word data
//   memory that drives the shared bus while d_mem_we is low and writes on
//   clock edges where d_mem_we is high. At init, word i holds i*i + 5, so
//   word 3 holds 14.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        d_mem_we;
  logic [5:0]  d_mem_addr;
  wire  [63:0] d_mem_data;

  load_store_unit #(.D_ADDR_BITS(6), .MEM_WORDS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .d_mem_we   (d_mem_we),
    .d_mem_addr (d_mem_addr),
    .d_mem_data (d_mem_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---- data memory model ----
  logic [63:0] mem [0:31];
  logic [63:0] mem_rd;
  logic        mem_init;
  int          we_cnt = 0;

  always_comb mem_rd = (d_mem_addr < 6'd32) ? mem[d_mem_addr[4:0]] : 64'd0;
  assign d_mem_data = d_mem_we ? 64'bz : mem_rd;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'(i * i + 5);
    end else if (d_mem_we) begin
      mem[d_mem_addr[4:0]] <= d_mem_data;
    end
    if (d_mem_we) we_cnt <= we_cnt + 1;
  end

  // ---- checking ----
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge, then scrambles the request fields.
  // On return, the unit is in the cycle after the accept.
  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = '1;
    req_wdata = ~d;
  endtask

  int we_base;
  int acc;
  int nrdy;
  int rsps;

  initial begin
    reset     = 1'b1;
    mem_init  = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_we",    64'(d_mem_we),  64'd0);
    mem_init = 1'b0;
    reset    = 1'b0;
    tick();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    check("rst_rdata",     rsp_rdata,      64'd0);
    check("rst_addr",      64'(d_mem_addr), 64'd0);

    // 1: load word 3 (preloaded 14)
    issue(1'b0, 64'h18, 64'd0);
    check("ld1_ready_busy", 64'(req_ready), 64'd0);
    check("ld1_no_rsp_t1",  64'(rsp_valid), 64'd0);
    check("ld1_we",         64'(d_mem_we),  64'd0);
    check("ld1_addr",       64'(d_mem_addr), 64'd3);
    tick();
    check("ld1_rsp_valid",  64'(rsp_valid), 64'd1);
    check("ld1_rsp_err",    64'(rsp_err),   64'd0);
    check("ld1_rdata",      rsp_rdata,      64'd14);
    tick();
    check("ld1_rsp_pulse",  64'(rsp_valid), 64'd0);
    check("ld1_ready_back", 64'(req_ready), 64'd1);

    // 2: store ABCD to idx 13, then load it back
    we_base = we_cnt;
    issue(1'b1, 64'h68, 64'h0000_0000_0000_ABCD);
    check("st2_we",      64'(d_mem_we),   64'd1);
    check("st2_addr",    64'(d_mem_addr), 64'd13);
    check("st2_bus",     d_mem_data,      64'hABCD);
    check("st2_no_rsp",  64'(rsp_valid),  64'd0);
    tick();
    check("st2_we_drop", 64'(d_mem_we),   64'd0);
    check("st2_rsp",     64'(rsp_valid),  64'd1);
    check("st2_err",     64'(rsp_err),    64'd0);
    check("st2_rdata_kept", rsp_rdata,    64'd14);
    tick();
    check("st2_we_cycles", 64'(we_cnt - we_base), 64'd1);
    issue(1'b0, 64'h68, 64'd0);
    check("ld2_bus_mem", d_mem_data, 64'hABCD);
    tick();
    check("ld2_rsp",   64'(rsp_valid), 64'd1);
    check("ld2_rdata", rsp_rdata,      64'hABCD);
    tick();

    // 3: error cases and the last valid word
    we_base = we_cnt;
    issue(1'b0, 64'h0C, 64'd0);
    check("mis_rsp",   64'(rsp_valid), 64'd1);
    check("mis_err",   64'(rsp_err),   64'd1);
    check("mis_ready", 64'(req_ready), 64'd0);
    tick();
    check("mis_done",  64'(rsp_valid), 64'd0);
    check("mis_idle",  64'(req_ready), 64'd1);
    check("mis_rdata_kept", rsp_rdata, 64'hABCD);
    issue(1'b1, 64'h100, 64'hDEAD);
    check("oor_rsp", 64'(rsp_valid), 64'd1);
    check("oor_err", 64'(rsp_err),   64'd1);
    check("oor_we",  64'(d_mem_we),  64'd0);
    tick();
    issue(1'b0, 64'h8000_0000_0000_0018, 64'd0);
    check("hi_err", 64'(rsp_err), 64'd1);
    tick();
    issue(1'b0, 64'hF8, 64'd0);
    tick();
    check("last_rsp",   64'(rsp_valid), 64'd1);
    check("last_err",   64'(rsp_err),   64'd0);
    check("last_rdata", rsp_rdata,      64'd966);
    tick();
    check("err_no_we", 64'(we_cnt - we_base), 64'd0);

    // 4: req_valid held for 9 cycles, alternating load/store on word 2
    we_base = we_cnt;
    acc  = 0;
    nrdy = 0;
    rsps = 0;
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1;
      req_write = i[0];
      req_addr  = 64'h10;
      req_wdata = 64'h1234_5678;
      if (req_ready) acc++;
      else nrdy++;
      if (rsp_valid) rsps++;
      tick();
    end
    req_valid = 1'b0;
    check("bb_accepts",  64'(acc),  64'd3);
    check("bb_not_rdy",  64'(nrdy), 64'd6);
    check("bb_rsps",     64'(rsps), 64'd3);
    check("bb_we_cycles", 64'(we_cnt - we_base), 64'd1);
    check("bb_rdata",    rsp_rdata, 64'h1234_5678);

    // 5: reset asserted during WR
    issue(1'b1, 64'h28, 64'h5555);
    check("rw_we_before", 64'(d_mem_we), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("rw_we_async",   64'(d_mem_we),   64'd0);
    check("rw_ready",      64'(req_ready),  64'd1);
    check("rw_rsp_valid",  64'(rsp_valid),  64'd0);
    check("rw_addr",       64'(d_mem_addr), 64'd0);
    check("rw_bus_mem",    d_mem_data,      64'd5);
    #2 reset = 1'b0;
    tick();
    check("rw_idle_after", 64'(req_ready),  64'd1);
    check("rw_no_rsp",     64'(rsp_valid),  64'd0);
    issue(1'b0, 64'h28, 64'd0);
    tick();
    check("rw_store_lost", rsp_rdata, 64'd30);
    tick();

    // 6: negative value round trip at idx 1
    issue(1'b1, 64'h08, 64'hFFFF_FFFF_FFFF_FFFB);
    tick();
    tick();
    issue(1'b0, 64'h08, 64'd0);
    tick();
    check("neg_rsp",   64'(rsp_valid), 64'd1);
    check("neg_rdata", rsp_rdata,      64'hFFFF_FFFF_FFFF_FFFB);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
